// File: rtl/mp3_pc_audio_pkg.sv
// Shared definitions for the audio-buffer playback reader: default widths,
// frame sizes in bytes, and the reader FSM encoding.
package mp3_pc_audio_pkg;

    localparam int ADDR_W_DEFAULT  = 15;
    localparam int UNDER_W_DEFAULT = 16;

    localparam logic [2:0] BYTES_PER_STEREO_FRAME = 3'd4;
    localparam logic [2:0] BYTES_PER_MONO_FRAME   = 3'd2;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_FETCH_ENC = 2'd1;
    localparam logic [1:0] ST_LOAD_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_FETCH = ST_FETCH_ENC,
        ST_LOAD  = ST_LOAD_ENC
    } rdr_state_t;

    // Number of buffer bytes that make up one frame.
    function automatic logic [2:0] frame_bytes(input logic mono);
        return mono ? BYTES_PER_MONO_FRAME : BYTES_PER_STEREO_FRAME;
    endfunction

endpackage

// File: rtl/mp3_pc_pcm_packer.sv
// Byte staging for one PCM frame. Counts fetch cycles (F0, F1, ...) and
// captures the buffer read data one cycle behind the issued address, then
// presents the little-endian 16-bit samples.
module mp3_pc_pcm_packer
    import mp3_pc_audio_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_step,
    input  logic        i_mono,
    input  logic [7:0]  i_rdata,
    output logic [2:0]  o_byte_idx,
    output logic [15:0] o_left,
    output logic [15:0] o_right
);

    logic [2:0] r_idx;
    logic [7:0] r_stage [0:3];
    logic [2:0] w_slot;
    logic       w_capture;

    // Read data for the address issued in Fn arrives in Fn+1, so F1 fills byte 0.
    assign w_slot    = r_idx - 3'd1;
    assign w_capture = i_step && (r_idx != 3'd0) && (r_idx <= BYTES_PER_STEREO_FRAME);

    // Fetch-cycle counter; restarts at F0 on every launch or flush, saturates past F4.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx <= 3'd0;
        end else if (i_clear) begin
            r_idx <= 3'd0;
        end else if (i_step && (r_idx <= BYTES_PER_STEREO_FRAME)) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // Staging bytes; a reset mid-fetch drops whatever was partially collected.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) begin
                r_stage[i] <= 8'h00;
            end
        end else if (w_capture) begin
            r_stage[w_slot[1:0]] <= i_rdata;
        end
    end

    assign o_byte_idx = r_idx;
    assign o_left     = {r_stage[1], r_stage[0]};
    assign o_right    = i_mono ? {r_stage[1], r_stage[0]} : {r_stage[3], r_stage[2]};

endmodule

// File: rtl/mp3_pc_audio_ram_reader.sv
// Playback-side drain of the dual-port audio buffer. Treats the buffer as a
// circular FIFO between rd_ptr (owned here) and the CPU's wr_ptr, fetches
// whole frames through port 2 and offers them on a valid/ready interface.
// Optional build macro: PCM_MONO_EN adds i_mono for 2-byte mono frames.
module mp3_pc_audio_ram_reader
    import mp3_pc_audio_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int UNDER_W = UNDER_W_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
`ifdef PCM_MONO_EN
    input  logic               i_mono,
`endif
    input  logic               i_flush,
    input  logic [ADDR_W-1:0]  i_wr_ptr,
    output logic [ADDR_W-1:0]  o_ram_address,
    output logic               o_ram_chipselect,
    output logic               o_ram_clken,
    output logic               o_ram_write,
    output logic [7:0]         o_ram_writedata,
    input  logic [7:0]         i_ram_readdata,
    output logic [15:0]        o_frame_left,
    output logic [15:0]        o_frame_right,
    output logic               o_frame_valid,
    input  logic               i_frame_ready,
    output logic [ADDR_W-1:0]  o_rd_ptr,
    output logic [ADDR_W-1:0]  o_level,
    output logic [UNDER_W-1:0] o_underrun_count
);

    localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [UNDER_W-1:0] UNDER_ONE = {{(UNDER_W-1){1'b0}}, 1'b1};

    rdr_state_t         r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0]  r_ram_address;
    logic               r_ram_en;
    logic [15:0]        r_frame_left, r_frame_right;
    logic               r_frame_valid;
    logic [UNDER_W-1:0] r_underrun;

    logic [ADDR_W-1:0]  w_level;
    logic [2:0]         w_need, w_nbytes, w_byte_idx;
    logic               w_frame_mono;
    logic               w_accept, w_start, w_issue_next;
    logic [15:0]        w_pk_left, w_pk_right;

`ifdef PCM_MONO_EN
    logic r_mono;

    // Frame format is latched at launch so a mid-fetch change of i_mono cannot split a frame.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mono <= 1'b0;
        end else if (w_start) begin
            r_mono <= i_mono;
        end
    end

    assign w_need       = frame_bytes(i_mono);
    assign w_frame_mono = r_mono;
`else
    assign w_need       = frame_bytes(1'b0);
    assign w_frame_mono = 1'b0;
`endif

    assign w_nbytes = frame_bytes(w_frame_mono);
    assign w_level  = i_wr_ptr - r_rd_ptr;
    assign w_accept = r_frame_valid && i_frame_ready;

    // A fetch only launches with a full frame buffered, so rd_ptr can never overtake wr_ptr.
    assign w_start = (r_state == ST_IDLE) && i_enable && !i_flush
                     && (w_level >= {{(ADDR_W-3){1'b0}}, w_need})
                     && (!r_frame_valid || i_frame_ready);

    // Next cycle presents an address: the launch edge sets up F0, F0..F(n-2) set up the rest.
    assign w_issue_next = w_start
                          || ((r_state == ST_FETCH) && !i_flush
                              && (w_byte_idx < (w_nbytes - 3'd1)));

    mp3_pc_pcm_packer u_packer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_start || i_flush),
        .i_step     (r_state == ST_FETCH),
        .i_mono     (w_frame_mono),
        .i_rdata    (i_ram_readdata),
        .o_byte_idx (w_byte_idx),
        .o_left     (w_pk_left),
        .o_right    (w_pk_right)
    );

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: flush aborts everything; FETCH ends once the last byte is captured.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_start) w_state_nxt = ST_FETCH;
                ST_FETCH: if (w_byte_idx == w_nbytes) w_state_nxt = ST_LOAD;
                ST_LOAD:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Port-2 address and read pointer; address holds its last value between fetches.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_ptr      <= '0;
            r_ram_address <= '0;
            r_ram_en      <= 1'b0;
        end else if (i_flush) begin
            r_rd_ptr <= i_wr_ptr;
            r_ram_en <= 1'b0;
        end else begin
            r_ram_en <= w_issue_next;
            if (w_issue_next) begin
                r_ram_address <= r_rd_ptr;
                r_rd_ptr      <= r_rd_ptr + ADDR_ONE;
            end
        end
    end

    // Output frame register and valid flag; flush beats a same-cycle acceptance.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_frame_left  <= 16'h0000;
            r_frame_right <= 16'h0000;
            r_frame_valid <= 1'b0;
        end else if (i_flush) begin
            r_frame_valid <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_frame_left  <= w_pk_left;
            r_frame_right <= w_pk_right;
            r_frame_valid <= 1'b1;
        end else if (w_accept) begin
            r_frame_valid <= 1'b0;
        end
    end

    // Saturating count of cycles where the DAC wanted data but none was ready.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_underrun <= '0;
        end else if (!i_flush && i_enable && i_frame_ready && !r_frame_valid
                     && (r_underrun != {UNDER_W{1'b1}})) begin
            r_underrun <= r_underrun + UNDER_ONE;
        end
    end

    assign o_ram_address    = r_ram_address;
    assign o_ram_chipselect = r_ram_en;
    assign o_ram_clken      = r_ram_en;
    assign o_ram_write      = 1'b0;
    assign o_ram_writedata  = 8'h00;
    assign o_frame_left     = r_frame_left;
    assign o_frame_right    = r_frame_right;
    assign o_frame_valid    = r_frame_valid;
    assign o_rd_ptr         = r_rd_ptr;
    assign o_level          = w_level;
    assign o_underrun_count = r_underrun;

endmodule
